mem_scrubber: RTL
=================

# mem_scrubber

Background memory scrubber for the Hardisc data memory. It walks a word-aligned address range and reads each word through the protected memory interface. When the interface reports a correctable error, it writes the corrected word back; uncorrectable errors are only reported. It sits beside the LSU as a low-priority requester on the shared data port, and an external arbiter gives the core priority. It is sequenced with the package ACM state encoding.

## Interface
Parameters:
- ADDR_BASE, 32'h80000000, first scrubbed byte address; must be 4-byte aligned.
- WORDS, 1024, number of 32-bit words in the range; must be ≥1.
- PERIOD_W, 16, width of the inter-access interval.

Ports:
- s_clk_i  in  1  clock.
- s_resetn_i  in  1  reset; asynchronous, active-low.
- s_enable_i  in  1  scrubbing enabled.
- s_period_i  in  PERIOD_W  idle cycles between accesses; 0 means back-to-back.
- s_clr_i  in  1  clears the correction counter.
- s_core_wr_i  in  1  core write granted this cycle (snoop).
- s_core_addr_i  in  32  byte address of that core write.
- m_req_o  out  1  memory request.
- m_we_o  out  1  1 = write, 0 = read.
- m_addr_o  out  32  word-aligned byte address.
- m_wdata_o  out  32  write-back data.
- m_gnt_i  in  1  request accepted this cycle.
- m_rvalid_i  in  1  read response valid.
- m_rdata_i  in  32  corrected read data.
- m_ce_i  in  1  correctable error on the response.
- m_uce_i  in  1  uncorrectable error on the response.
- s_ce_cnt_o  out  16  saturating count of completed write-backs.
- s_uce_o  out  1  one-cycle pulse on an uncorrectable response.
- s_uce_addr_o  out  32  address of the last uncorrectable response.
- s_pass_done_o  out  1  one-cycle pulse when the address wraps.

## Operation
- States use ACM_IDLE, ACM_CHECK and ACM_CORRECT from p_hardisc.
- **ACM_IDLE**: the interval counter counts up while s_enable_i=1 and holds at 0 while s_enable_i=0. When counter ≥ s_period_i and s_enable_i=1, go to ACM_CHECK and clear the counter.
- **ACM_CHECK, request phase**: m_req_o=1, m_we_o=0, m_addr_o = current address. Hold until m_gnt_i.
- **ACM_CHECK, response phase** (pending flag set on grant, m_req_o=0): wait for m_rvalid_i.
  - m_uce_i=1 (takes priority over m_ce_i): pulse s_uce_o, latch s_uce_addr_o, advance the address, go to ACM_IDLE.
  - m_ce_i=1 and no snoop hit: latch m_rdata_i into m_wdata_o, go to ACM_CORRECT.
  - Otherwise: advance the address, go to ACM_IDLE.
- **ACM_CORRECT**: m_req_o=1, m_we_o=1, same address. On m_gnt_i: increment s_ce_cnt_o (saturates at 16'hFFFF), advance the address, go to ACM_IDLE.
- **Snoop hit**: s_core_wr_i=1 with s_core_addr_i[31:2] equal to the current address[31:2].
  - A hit in the response phase or in ACM_CORRECT before grant cancels the write-back; the counter does not increment and the address still advances.
  - A hit in the same cycle as the ACM_CORRECT grant still counts as completed, because the arbiter orders the core write after it.
- **Address advance**: +4 per step. After ADDR_BASE + 4·(WORDS−1) the address wraps to ADDR_BASE and s_pass_done_o pulses in the same cycle as the advance.
- **s_enable_i deasserted mid-operation**: an outstanding read or granted-pending write completes normally, then the block stays in ACM_IDLE. The address is retained, so scrubbing resumes where it stopped.
- m_rvalid_i outside the response phase is ignored.
- s_clr_i has priority over a same-cycle increment; the count becomes 0.

## Timing
- **Reset values**: state ACM_IDLE, address ADDR_BASE, m_req_o=0, m_we_o=0, m_addr_o=ADDR_BASE, m_wdata_o=0, s_ce_cnt_o=0, s_uce_o=0, s_uce_addr_o=0, s_pass_done_o=0, pending=0. Reset mid-transaction discards the transaction.
- All outputs are registered.
- m_req_o rises the cycle after the interval expires.
- With m_gnt_i and m_rvalid_i both immediate, a clean word costs 3 cycles: request, response, idle.
- A corrected word adds a minimum of 1 cycle for the write request.
- Minimum spacing between successive reads is s_period_i + 3 cycles.
- m_addr_o and m_we_o are stable while m_req_o=1 and not yet granted.

## Structure
- ACM_* constants are already in p_hardisc and are reused as the state type.
- Add to p_hardisc:
  - a packed struct scrub_stat_t {ce_cnt, uce_addr};
  - a CSR constant CSR_MSCRUB at 12'h7C1 for future exposure of period/enable.
- Sub-module scrub_timer holds the interval counter (count, clear, compare against s_period_i). Everything else stays inline.

## Test plan
- WORDS=4, s_period_i=0, clean responses, immediate gnt/rvalid → reads at 0x80000000, …04, …08, …0C, then wrap; s_pass_done_o pulses exactly once per 4 reads; ce_cnt stays 0.
- Response to 0x80000008 with m_ce_i=1, rdata 0xDEADBEEF → next request is a write to 0x80000008 with data 0xDEADBEEF; ce_cnt becomes 1 on its grant.
- m_ce_i=1 and m_uce_i=1 together at 0x80000004 → no write, s_uce_o pulses once, s_uce_addr_o=0x80000004.
- m_ce_i=1, then a core write to 0x8000000C while ACM_CORRECT is waiting with m_gnt_i held low 5 cycles → write-back cancelled, ce_cnt unchanged, next read is at 0x80000010 (WORDS ≥5).
- s_period_i=10, s_enable_i dropped while the read is pending → the read completes, no new request follows; re-enable → the next read starts 11 cycles later at the next address.
- s_resetn_i asserted during the ACM_CORRECT request → all outputs at reset values; after release the first read is at ADDR_BASE.

Source files
------------

// File: rtl/p_hardisc.sv
// Shared Hardisc package: ACM sequencing states, scrubber status bundle
// and CSR addresses.
package p_hardisc;

   typedef enum logic [1:0] {
      ACM_IDLE    = 2'b00,
      ACM_CHECK   = 2'b01,
      ACM_CORRECT = 2'b10
   } acm_state_t;

   localparam logic [11:0] CSR_MSCRUB = 12'h7C1;

   typedef struct packed {
      logic [15:0] ce_cnt;
      logic [31:0] uce_addr;
   } scrub_stat_t;

   function automatic logic [15:0] sat_inc16(logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/scrub_timer.sv
// Interval counter for the memory scrubber: counts idle cycles and
// flags when the programmed period has elapsed.
module scrub_timer
   import p_hardisc::*;
#(
   parameter int PERIOD_W = 16
) (
   input  logic                s_clk_i,
   input  logic                s_resetn_i,
   input  logic                cnt_en_i,
   input  logic                cnt_clr_i,
   input  logic [PERIOD_W-1:0] period_i,
   output logic                expired_o
);

   logic [PERIOD_W-1:0] cnt_q;

   always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
      if (!s_resetn_i) begin
         cnt_q <= '0;
      end else if (cnt_clr_i) begin
         cnt_q <= '0;
      end else if (cnt_en_i && (cnt_q != '1)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign expired_o = (cnt_q >= period_i);

endmodule

// File: rtl/mem_scrubber.sv
// Background data-memory scrubber: reads each word of a range and writes
// back corrected data, reporting uncorrectable errors.
module mem_scrubber
   import p_hardisc::*;
#(
   parameter logic [31:0] ADDR_BASE = 32'h80000000,
   parameter int          WORDS     = 1024,
   parameter int          PERIOD_W  = 16
) (
   input  logic                s_clk_i,
   input  logic                s_resetn_i,
   input  logic                s_enable_i,
   input  logic [PERIOD_W-1:0] s_period_i,
   input  logic                s_clr_i,
   input  logic                s_core_wr_i,
   input  logic [31:0]         s_core_addr_i,
   output logic                m_req_o,
   output logic                m_we_o,
   output logic [31:0]         m_addr_o,
   output logic [31:0]         m_wdata_o,
   input  logic                m_gnt_i,
   input  logic                m_rvalid_i,
   input  logic [31:0]         m_rdata_i,
   input  logic                m_ce_i,
   input  logic                m_uce_i,
   output logic [15:0]         s_ce_cnt_o,
   output logic                s_uce_o,
   output logic [31:0]         s_uce_addr_o,
   output logic                s_pass_done_o
);

   localparam logic [31:0] LAST_ADDR = ADDR_BASE + 32'((WORDS - 1) * 4);

   acm_state_t  state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   scrub_stat_t stat_q, stat_d;
   logic        pend_q, pend_d;
   logic        req_q, req_d;
   logic        we_q, we_d;
   logic        uce_q, uce_d;
   logic        pass_q, pass_d;

   logic        expired;
   logic        tmr_en;
   logic        tmr_clr;
   logic        snoop_hit;
   logic        advance;
   logic        wrap;
   logic        unused_addr_lsb;

   assign unused_addr_lsb = ^s_core_addr_i[1:0];

   assign snoop_hit = s_core_wr_i && (s_core_addr_i[31:2] == addr_q[31:2]);
   assign wrap      = (addr_q == LAST_ADDR);

   scrub_timer #(
      .PERIOD_W (PERIOD_W)
   ) u_timer (
      .s_clk_i    (s_clk_i),
      .s_resetn_i (s_resetn_i),
      .cnt_en_i   (tmr_en),
      .cnt_clr_i  (tmr_clr),
      .period_i   (s_period_i),
      .expired_o  (expired)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      stat_d  = stat_q;
      pend_d  = pend_q;
      req_d   = req_q;
      we_d    = we_q;
      uce_d   = 1'b0;
      pass_d  = 1'b0;
      advance = 1'b0;
      tmr_en  = 1'b0;
      tmr_clr = 1'b0;

      unique case (state_q)
         ACM_IDLE: begin
            tmr_en  = s_enable_i;
            tmr_clr = !s_enable_i;
            if (s_enable_i && expired) begin
               tmr_clr = 1'b1;
               state_d = ACM_CHECK;
               req_d   = 1'b1;
               we_d    = 1'b0;
            end
         end
         ACM_CHECK: begin
            if (!pend_q) begin
               if (m_gnt_i) begin
                  pend_d = 1'b1;
                  req_d  = 1'b0;
               end
            end else if (m_rvalid_i) begin
               pend_d = 1'b0;
               if (m_uce_i) begin
                  uce_d           = 1'b1;
                  stat_d.uce_addr = addr_q;
                  advance         = 1'b1;
                  state_d         = ACM_IDLE;
               end else if (m_ce_i && !snoop_hit) begin
                  wdata_d = m_rdata_i;
                  state_d = ACM_CORRECT;
                  req_d   = 1'b1;
                  we_d    = 1'b1;
               end else begin
                  advance = 1'b1;
                  state_d = ACM_IDLE;
               end
            end
         end
         ACM_CORRECT: begin
            // Grant wins over a same-cycle snoop: the core write lands after.
            if (m_gnt_i) begin
               stat_d.ce_cnt = sat_inc16(stat_q.ce_cnt);
               advance       = 1'b1;
               state_d       = ACM_IDLE;
               req_d         = 1'b0;
               we_d          = 1'b0;
            end else if (snoop_hit) begin
               advance = 1'b1;
               state_d = ACM_IDLE;
               req_d   = 1'b0;
               we_d    = 1'b0;
            end
         end
         default: begin
            state_d = ACM_IDLE;
            req_d   = 1'b0;
            we_d    = 1'b0;
            pend_d  = 1'b0;
         end
      endcase

      if (advance) begin
         addr_d = wrap ? ADDR_BASE : addr_q + 32'd4;
         pass_d = wrap;
      end

      if (s_clr_i) begin
         stat_d.ce_cnt = '0;
      end
   end

   always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
      if (!s_resetn_i) begin
         state_q <= ACM_IDLE;
         addr_q  <= ADDR_BASE;
         wdata_q <= '0;
         stat_q  <= '0;
         pend_q  <= 1'b0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         uce_q   <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         stat_q  <= stat_d;
         pend_q  <= pend_d;
         req_q   <= req_d;
         we_q    <= we_d;
         uce_q   <= uce_d;
         pass_q  <= pass_d;
      end
   end

   assign m_req_o       = req_q;
   assign m_we_o        = we_q;
   assign m_addr_o      = addr_q;
   assign m_wdata_o     = wdata_q;
   assign s_ce_cnt_o    = stat_q.ce_cnt;
   assign s_uce_o       = uce_q;
   assign s_uce_addr_o  = stat_q.uce_addr;
   assign s_pass_done_o = pass_q;

endmodule
